// File: rtl/vx_sau_gemm_engine.sv
// NxN output-stationary systolic GEMM engine: operand row storage, skewed edge feeder,
// PE grid with local accumulators, and a valid/ready result row streamer.
module vx_sau_gemm_engine #(
   parameter int unsigned N      = 4,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ACC_W  = 32,
   parameter bit          SIGNED = 1'b1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   ld_valid,
   output logic                   ld_ready,
   input  logic                   ld_sel,
   input  logic [$clog2(N)-1:0]   ld_row,
   input  logic [N*DATA_W-1:0]    ld_data,
   input  logic                   start,
   input  logic                   acc_mode,
   output logic                   busy,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [$clog2(N)-1:0]   res_row,
   output logic [N*ACC_W-1:0]     res_data
);

   localparam int unsigned IW = $clog2(N);
   localparam int unsigned CW = $clog2(3 * N);
   localparam int          NI = int'(N);
   localparam logic [CW-1:0] LastT   = CW'(3 * N - 3);
   localparam logic [IW-1:0] LastRow = IW'(N - 1);

   typedef enum logic [1:0] {StIdle, StFeed, StDrain, StOutput} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [IW-1:0]   row_q, row_d;
   logic            start_fire;
   logic            computing;
   logic            row_ok;

   logic [DATA_W-1:0] a_mem [N][N];
   logic [DATA_W-1:0] b_mem [N][N];
   logic [DATA_W-1:0] a_edge [N];
   logic [DATA_W-1:0] b_edge [N];
   // a_reg[i][0] / b_reg[0][j] are the edge registers; the rest form the pass-through mesh.
   logic [DATA_W-1:0] a_reg [N][N];
   logic [DATA_W-1:0] b_reg [N][N];
   logic [ACC_W-1:0]  acc [N][N];

   function automatic logic [ACC_W-1:0] ext(input logic [DATA_W-1:0] v);
      logic sign;
      sign = SIGNED && v[DATA_W-1];
      return {{(ACC_W - DATA_W){sign}}, v};
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         row_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         row_q   <= row_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      row_d      = row_q;
      start_fire = 1'b0;
      ld_ready   = 1'b0;
      busy       = 1'b1;
      res_valid  = 1'b0;
      case (state_q)
         StIdle: begin
            busy     = 1'b0;
            ld_ready = reset;
            if (start) begin
               start_fire = 1'b1;
               state_d    = StFeed;
               cnt_d      = '0;
            end
         end
         StFeed: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LastT) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            state_d = StOutput;
            row_d   = '0;
         end
         StOutput: begin
            res_valid = 1'b1;
            if (res_ready) begin
               if (row_q == LastRow) begin
                  state_d = StIdle;
                  row_d   = '0;
               end else begin
                  row_d = row_q + 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign computing = (state_q == StFeed) || (state_q == StDrain);
   assign row_ok    = 32'(ld_row) < N;

   // Loads are written at the same edge a start is accepted, so FEED sees the new row.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NI; i++) begin
            for (int k = 0; k < NI; k++) begin
               a_mem[i][k] <= '0;
               b_mem[i][k] <= '0;
            end
         end
      end else if (ld_valid && ld_ready && row_ok) begin
         for (int k = 0; k < NI; k++) begin
            if (ld_sel) begin
               b_mem[ld_row][k] <= ld_data[k*DATA_W +: DATA_W];
            end else begin
               a_mem[ld_row][k] <= ld_data[k*DATA_W +: DATA_W];
            end
         end
      end
   end

   // Skewed feed: left register i takes A[i][t-i], top register j takes B[t-j][j].
   always_comb begin
      int k;
      k = 0;
      for (int i = 0; i < NI; i++) begin
         a_edge[i] = '0;
         b_edge[i] = '0;
      end
      if (state_q == StFeed) begin
         for (int i = 0; i < NI; i++) begin
            k = int'(cnt_q) - i;
            if (k >= 0 && k < NI) begin
               a_edge[i] = a_mem[i][k[IW-1:0]];
               b_edge[i] = b_mem[k[IW-1:0]][i];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NI; i++) begin
            for (int j = 0; j < NI; j++) begin
               a_reg[i][j] <= '0;
               b_reg[i][j] <= '0;
               acc[i][j]   <= '0;
            end
         end
      end else if (start_fire) begin
         // Flush stale mesh operands so the first FEED edge multiplies zeros.
         for (int i = 0; i < NI; i++) begin
            for (int j = 0; j < NI; j++) begin
               a_reg[i][j] <= '0;
               b_reg[i][j] <= '0;
               if (!acc_mode) begin
                  acc[i][j] <= '0;
               end
            end
         end
      end else if (computing) begin
         for (int i = 0; i < NI; i++) begin
            a_reg[i][0] <= a_edge[i];
            b_reg[0][i] <= b_edge[i];
         end
         for (int i = 0; i < NI; i++) begin
            for (int j = 1; j < NI; j++) begin
               a_reg[i][j] <= a_reg[i][j-1];
               b_reg[j][i] <= b_reg[j-1][i];
            end
         end
         for (int i = 0; i < NI; i++) begin
            for (int j = 0; j < NI; j++) begin
               acc[i][j] <= acc[i][j] + ext(a_reg[i][j]) * ext(b_reg[i][j]);
            end
         end
      end
   end

   assign res_row = row_q;

   always_comb begin
      for (int j = 0; j < NI; j++) begin
         res_data[j*ACC_W +: ACC_W] = res_valid ? acc[row_q][j] : '0;
      end
   end

endmodule

// File: tb/tb_vx_sau_gemm_engine.sv
// Scoreboard bench: signed and unsigned engines run in lockstep on shared inputs and are
// checked row by row against a behavioural matrix model.
module tb_vx_sau_gemm_engine;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         ld_valid = 1'b0;
   logic         ld_sel = 1'b0;
   logic [1:0]   ld_row = '0;
   logic [31:0]  ld_data = '0;
   logic         start = 1'b0;
   logic         acc_mode = 1'b0;
   logic         res_ready = 1'b0;

   logic         ld_ready, busy, res_valid;
   logic [1:0]   res_row;
   logic [127:0] res_data;
   logic         u_ld_ready, u_busy, u_res_valid;
   logic [1:0]   u_res_row;
   logic [127:0] u_res_data;

   always #5 clk = ~clk;

   vx_sau_gemm_engine #(.N(4), .DATA_W(8), .ACC_W(32), .SIGNED(1'b1)) u_dut (
      .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_sel(ld_sel),
      .ld_row(ld_row), .ld_data(ld_data), .start(start), .acc_mode(acc_mode), .busy(busy),
      .res_valid(res_valid), .res_ready(res_ready), .res_row(res_row), .res_data(res_data)
   );

   vx_sau_gemm_engine #(.N(4), .DATA_W(8), .ACC_W(32), .SIGNED(1'b0)) u_dut_u (
      .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_ready(u_ld_ready), .ld_sel(ld_sel),
      .ld_row(ld_row), .ld_data(ld_data), .start(start), .acc_mode(acc_mode), .busy(u_busy),
      .res_valid(u_res_valid), .res_ready(res_ready), .res_row(u_res_row),
      .res_data(u_res_data)
   );

   typedef struct {
      logic [1:0]   row;
      logic [127:0] ds;
      logic [127:0] du;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          failures = 0;
   logic [7:0]  ma [4][4];
   logic [7:0]  mb [4][4];
   logic [31:0] mcs [4][4];
   logic [31:0] mcu [4][4];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] mul(input logic [7:0] a, input logic [7:0] b, input bit sgn);
      int x, y;
      if (sgn) begin
         x = int'($signed(a));
         y = int'($signed(b));
      end else begin
         x = int'({24'b0, a});
         y = int'({24'b0, b});
      end
      return 32'(x * y);
   endfunction

   task automatic clear_model;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            ma[i][j] = '0; mb[i][j] = '0; mcs[i][j] = '0; mcu[i][j] = '0;
         end
      end
   endtask

   task automatic compute_push(input bit accm);
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         e.row = 2'(i);
         for (int j = 0; j < 4; j++) begin
            logic [31:0] ss, su;
            ss = '0; su = '0;
            for (int k = 0; k < 4; k++) begin
               ss = ss + mul(ma[i][k], mb[k][j], 1'b1);
               su = su + mul(ma[i][k], mb[k][j], 1'b0);
            end
            mcs[i][j] = accm ? mcs[i][j] + ss : ss;
            mcu[i][j] = accm ? mcu[i][j] + su : su;
            e.ds[j*32 +: 32] = mcs[i][j];
            e.du[j*32 +: 32] = mcu[i][j];
         end
         sb.push_back(e);
      end
   endtask

   task automatic load_row(input bit sel, input int r, input logic [31:0] d);
      ld_valid = 1'b1; ld_sel = sel; ld_row = 2'(r); ld_data = d;
      checks++;
      if (ld_ready !== 1'b1 || u_ld_ready !== 1'b1) begin
         failures++;
         $display("FAIL load_ready row=%0d got=%b/%b exp=1", r, ld_ready, u_ld_ready);
      end
      tick;
      ld_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (sel) mb[r][k] = d[k*8 +: 8];
         else     ma[r][k] = d[k*8 +: 8];
      end
   endtask

   task automatic load_mat(input bit sel, input logic [31:0] r0, input logic [31:0] r1,
                           input logic [31:0] r2, input logic [31:0] r3);
      load_row(sel, 0, r0);
      load_row(sel, 1, r1);
      load_row(sel, 2, r2);
      load_row(sel, 3, r3);
   endtask

   // mode 0: res_ready held high; mode 1: 5-cycle stall on row 0 then alternate.
   task automatic run_op(input string name, input bit accm, input int mode, input int exp_first,
                         input int exp_idle, input bit intrude);
      int           cyc, first, idle, vcnt;
      bit           stall;
      logic [1:0]   prow;
      logic [127:0] pds;
      exp_t         e;
      compute_push(accm);
      acc_mode = accm; start = 1'b1;
      tick;
      start = 1'b0; ld_valid = 1'b0;
      cyc = 1; first = -1; idle = -1; vcnt = 0; stall = 1'b0; prow = '0; pds = '0;
      checks++;
      if (busy !== 1'b1) begin
         failures++; $display("FAIL %s busy_at_cycle1 got=%b exp=1", name, busy);
      end
      while (cyc < 300) begin
         if (mode == 1) res_ready = (res_valid === 1'b1) && vcnt >= 5 && ((vcnt - 5) % 2 == 0);
         else           res_ready = 1'b1;
         if (intrude && cyc == 3) begin
            ld_valid = 1'b1; ld_sel = 1'b0; ld_row = 2'd0; ld_data = 32'hFFFF_FFFF;
            start = 1'b1; acc_mode = 1'b0;
            checks++;
            if (ld_ready !== 1'b0) begin
               failures++; $display("FAIL %s ld_ready_busy got=%b exp=0", name, ld_ready);
            end
         end
         if (intrude && cyc == 4) begin
            ld_valid = 1'b0; start = 1'b0;
         end
         if (res_valid === 1'b1 && first < 0) first = cyc;
         if (stall) begin
            checks++;
            if (res_valid !== 1'b1 || res_row !== prow || res_data !== pds) begin
               failures++;
               $display("FAIL %s hold cyc=%0d got row=%0d data=%h exp row=%0d data=%h",
                        name, cyc, res_row, res_data, prow, pds);
            end
         end
         if (res_valid === 1'b1 && res_ready) begin
            checks++;
            if (sb.size() == 0) begin
               failures++; $display("FAIL %s extra_row got=%0d exp=none", name, res_row);
            end else begin
               e = sb.pop_front();
               if (res_row !== e.row || res_data !== e.ds) begin
                  failures++;
                  $display("FAIL %s signed_row got row=%0d data=%h exp row=%0d data=%h",
                           name, res_row, res_data, e.row, e.ds);
               end
               checks++;
               if (u_res_valid !== 1'b1 || u_res_row !== e.row || u_res_data !== e.du) begin
                  failures++;
                  $display("FAIL %s unsigned_row got row=%0d data=%h exp row=%0d data=%h",
                           name, u_res_row, u_res_data, e.row, e.du);
               end
            end
         end
         stall = (res_valid === 1'b1) && !res_ready;
         prow = res_row; pds = res_data;
         if (res_valid === 1'b1) vcnt++;
         if (busy === 1'b0) begin
            idle = cyc;
            break;
         end
         tick;
         cyc++;
      end
      checks++;
      if (idle < 0) begin
         failures++; $display("FAIL %s timeout got=busy exp=idle", name);
      end
      checks++;
      if (sb.size() != 0) begin
         failures++; $display("FAIL %s missing_rows got=%0d left exp=0", name, sb.size());
      end
      sb.delete();
      if (exp_first >= 0) begin
         checks++;
         if (first != exp_first) begin
            failures++; $display("FAIL %s first_valid got=%0d exp=%0d", name, first, exp_first);
         end
      end
      if (exp_idle >= 0) begin
         checks++;
         if (idle != exp_idle) begin
            failures++; $display("FAIL %s idle_cycle got=%0d exp=%0d", name, idle, exp_idle);
         end
      end
      checks++;
      if (res_valid !== 1'b0 || ld_ready !== 1'b1 || u_busy !== 1'b0) begin
         failures++;
         $display("FAIL %s idle_outputs got valid=%b ready=%b ubusy=%b exp 0/1/0",
                  name, res_valid, ld_ready, u_busy);
      end
   endtask

   task automatic test_reset;
      clear_model;
      #2;
      checks++;
      if (busy !== 1'b0 || res_valid !== 1'b0 || res_row !== 2'd0 || res_data !== '0 ||
          ld_ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs got busy=%b valid=%b row=%0d data=%h ready=%b exp 0",
                  busy, res_valid, res_row, res_data, ld_ready);
      end
      #10 reset = 1'b1;
      tick;
      checks++;
      if (busy !== 1'b0 || ld_ready !== 1'b1) begin
         failures++; $display("FAIL reset_release got busy=%b ready=%b exp 0/1", busy, ld_ready);
      end
   endtask

   task automatic test_identity;
      load_mat(1'b0, 32'h0000_0001, 32'h0000_0100, 32'h0001_0000, 32'h0100_0000);
      load_mat(1'b1, 32'h0403_0201, 32'h0807_0605, 32'h0C0B_0A09, 32'h100F_0E0D);
      run_op("identity", 1'b0, 0, 12, 16, 1'b0);
   endtask

   task automatic test_corners;
      load_mat(1'b0, 32'h8080_8080, 32'h8080_8080, 32'h8080_8080, 32'h8080_8080);
      load_mat(1'b1, 32'h8080_8080, 32'h8080_8080, 32'h8080_8080, 32'h8080_8080);
      run_op("corner_80", 1'b0, 0, 12, 16, 1'b0);
      load_mat(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      load_mat(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op("corner_ff", 1'b0, 0, 12, 16, 1'b0);
   endtask

   task automatic test_accumulate;
      load_mat(1'b0, 32'h0403_0201, 32'h0807_0605, 32'h0C0B_0A09, 32'h100F_0E0D);
      load_mat(1'b1, 32'h0000_0001, 32'h0000_0100, 32'h0001_0000, 32'h0100_0000);
      run_op("acc_first", 1'b0, 0, 12, 16, 1'b0);
      run_op("acc_second", 1'b1, 0, 12, 16, 1'b0);
   endtask

   task automatic test_backpressure;
      load_mat(1'b1, 32'h0305_F902, 32'h7F01_8011, 32'h0A0B_0C0D, 32'hFE02_FD03);
      run_op("backpressure", 1'b0, 1, 12, -1, 1'b0);
   endtask

   task automatic test_busy_block;
      run_op("busy_block", 1'b0, 0, 12, 16, 1'b1);
   endtask

   task automatic test_same_cycle;
      ld_valid = 1'b1; ld_sel = 1'b0; ld_row = 2'd0; ld_data = 32'h0504_0302;
      ma[0][0] = 8'h02; ma[0][1] = 8'h03; ma[0][2] = 8'h04; ma[0][3] = 8'h05;
      run_op("same_cycle", 1'b0, 0, 12, 16, 1'b0);
   endtask

   task automatic test_reset_mid;
      acc_mode = 1'b0; start = 1'b1;
      tick;
      start = 1'b0;
      repeat (4) tick;
      reset = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || res_valid !== 1'b0 || ld_ready !== 1'b0 || res_row !== 2'd0 ||
          res_data !== '0 || u_busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid got busy=%b valid=%b ready=%b row=%0d exp 0/0/0/0",
                  busy, res_valid, ld_ready, res_row);
      end
      clear_model;
      tick;
      reset = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0 || ld_ready !== 1'b1) begin
         failures++; $display("FAIL reset_mid_release got busy=%b ready=%b exp 0/1", busy, ld_ready);
      end
      tick;
      load_mat(1'b0, 32'h0102_0304, 32'hFF00_0102, 32'h1020_3040, 32'h0909_0909);
      load_mat(1'b1, 32'h0100_0001, 32'h0002_0200, 32'h8001_0003, 32'h0004_7F04);
      // acc_mode=1 exposes any accumulator contents that survived the reset.
      run_op("after_reset", 1'b1, 0, 12, 16, 1'b0);
   endtask

   initial begin
      test_reset;
      test_identity;
      test_corners;
      test_accumulate;
      test_backpressure;
      test_busy_block;
      test_same_cycle;
      test_reset_mid;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
